// File: rtl/ogpu_cmd_fifo_pio.sv
// ogpu_cmd_fifo_pio
//   Avalon-MM command PIO with a first-word-fall-through command FIFO that
//   feeds the raster unit over valid/ready. It also counts outstanding
//   commands and completions so software can poll for progress.
//
// Ports
//   clk, reset             single clock domain, synchronous active-high reset
//   address, chipselect,   Avalon-MM slave; write strobe = chipselect & ~write_n
//   write_n, writedata     0 CMD, 1 STATUS, 2 CONTROL, 3 DONE
//   readdata               combinational read mux, zero wait states
//   cmd_data, cmd_valid    FIFO head word / FIFO non-empty
//   cmd_ready              raster unit takes the head word
//   cmd_done               one-cycle pulse per completed command
//   irq                    completion interrupt (only with OGPU_CMD_IRQ_EN)
//
// Build option
//   OGPU_CMD_IRQ_EN  adds the irq port and the CONTROL irq enable/pending bits.

module ogpu_cmd_fifo_pio #(
  parameter int unsigned CMD_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  input  logic                 cmd_done
`ifdef OGPU_CMD_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OUT_W = LEVEL_W + 8;

  typedef enum logic [1:0] {
    REG_CMD    = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_DONE   = 2'd3
  } reg_e;

  reg_e reg_sel;

  // Register state
  logic [CMD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CMD_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [CMD_WIDTH-1:0] last_cmd_q, last_cmd_d;
  logic                 overflow_q, overflow_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [31:0]          done_count_q, done_count_d;

  // Decoded strobes
  logic wr;
  logic cmd_wr;
  logic ctrl_wr;
  logic flush;
  logic clr_ovf;
  logic clr_done;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic ovf_set;
  logic busy;

`ifdef OGPU_CMD_IRQ_EN
  logic irq_enable_q,  irq_enable_d;
  logic irq_pending_q, irq_pending_d;
  logic irq_q,         irq_d;
  logic drain_done;
`endif

  // Bits of writedata that no register consumes in this configuration.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_comb begin
    reg_sel  = reg_e'(address);
    wr       = chipselect & ~write_n;
    cmd_wr   = wr && (reg_sel == REG_CMD);
    ctrl_wr  = wr && (reg_sel == REG_CTRL);
    flush    = ctrl_wr & writedata[0];
    clr_ovf  = ctrl_wr & writedata[1];
    clr_done = ctrl_wr & writedata[2];

    full      = (level_q == LEVEL_W'(FIFO_DEPTH));
    empty     = (level_q == '0);
    cmd_valid = ~empty;
    cmd_data  = mem_q[rd_ptr_q];
    pop       = cmd_valid & cmd_ready;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    push    = cmd_wr & (~full | pop);
    ovf_set = cmd_wr & full & ~pop;
    busy    = cmd_valid | (outstanding_q != '0);
  end

  // FIFO pointers, storage and level
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_cmd_d = last_cmd_q;

    if (push) begin
      mem_d[wr_ptr_q] = writedata[CMD_WIDTH-1:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      last_cmd_d      = writedata[CMD_WIDTH-1:0];
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase

    // Flush comes from CONTROL, so it never coincides with a push; a pop in
    // the same cycle has already been accounted for in outstanding.
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      level_d  = '0;
    end
  end

  // Status counters
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    outstanding_d = outstanding_q;
    if (pop && !cmd_done) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!pop && cmd_done && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    done_count_d = done_count_q;
    if (clr_done) begin
      done_count_d = '0;
    end else if (cmd_done) begin
      done_count_d = done_count_q + 32'd1;
    end
  end

`ifdef OGPU_CMD_IRQ_EN
  always_comb begin
    irq_enable_d = irq_enable_q;
    if (ctrl_wr && writedata[3]) begin
      irq_enable_d = writedata[4];
    end

    // The last completion retires while nothing is left queued.
    drain_done = cmd_done && !pop && empty && (outstanding_q == OUT_W'(1));

    irq_pending_d = irq_pending_q;
    if (drain_done) begin
      irq_pending_d = 1'b1;
    end else if (ctrl_wr && writedata[5]) begin
      irq_pending_d = 1'b0;
    end

    irq_d = irq_pending_d & irq_enable_d;
  end

  assign irq = irq_q;
`endif

  // Read mux
  always_comb begin
    readdata = '0;
    case (reg_sel)
      REG_CMD: begin
        readdata[CMD_WIDTH-1:0] = last_cmd_q;
      end
      REG_STATUS: begin
        readdata[LEVEL_W-1:0] = level_q;
        readdata[8]           = empty;
        readdata[9]           = full;
        readdata[10]          = overflow_q;
        readdata[11]          = busy;
      end
      REG_CTRL: begin
`ifdef OGPU_CMD_IRQ_EN
        readdata[0] = irq_enable_q;
        readdata[1] = irq_pending_q;
`endif
      end
      REG_DONE: begin
        readdata = done_count_q;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      last_cmd_q    <= '0;
      overflow_q    <= 1'b0;
      outstanding_q <= '0;
      done_count_q  <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      last_cmd_q    <= last_cmd_d;
      overflow_q    <= overflow_d;
      outstanding_q <= outstanding_d;
      done_count_q  <= done_count_d;
    end
  end

`ifdef OGPU_CMD_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable_q  <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      irq_enable_q  <= irq_enable_d;
      irq_pending_q <= irq_pending_d;
      irq_q         <= irq_d;
    end
  end
`endif

endmodule

// File: tb/tb_ogpu_cmd_fifo_pio.sv
`timescale 1ns/1ps
module tb_ogpu_cmd_fifo_pio;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_done;
`ifdef OGPU_CMD_IRQ_EN
  logic             irq;
`endif

  ogpu_cmd_fifo_pio #(
    .CMD_WIDTH (CMD_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_done  (cmd_done)
`ifdef OGPU_CMD_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Scoreboard: commands the bench expects to leave the FIFO, in order.
  logic [CMD_W-1:0] exp_q[$];
  logic             pend_push  = 1'b0;
  logic             pend_flush = 1'b0;
  logic [CMD_W-1:0] pend_data  = '0;
  int unsigned      m_pops     = 0;
  logic [31:0]      rd;

  // Evaluated mid-cycle, ahead of the edge that commits pops and pushes.
  always @(negedge clk) begin
    logic [CMD_W-1:0] head;
    if (reset) begin
      exp_q.delete();
    end else begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        if (cmd_valid !== 1'b0) begin
          n_err++;
          $display("FAIL sb_empty: cmd_valid=%b expected 0 at %0t", cmd_valid, $time);
        end
      end else begin
        head = exp_q[0];
        if (cmd_valid !== 1'b1 || cmd_data !== head) begin
          n_err++;
          $display("FAIL sb_head: cmd_valid=%b cmd_data=%h expected valid=1 data=%h at %0t",
                   cmd_valid, cmd_data, head, $time);
        end
        if (cmd_ready) begin
          head = exp_q.pop_front();
          m_pops++;
        end
      end
      if (pend_push && exp_q.size() < DEPTH) exp_q.push_back(pend_data);
      if (pend_flush) exp_q.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    pend_push  = (a == 2'd0);
    pend_data  = d[CMD_W-1:0];
    pend_flush = (a == 2'd2) && d[0];
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
    cyc();
  endtask

  task automatic pulse_done(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cmd_done = 1'b1;
      cyc();
      cmd_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h100; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0 || cmd_data !== '0) begin
      n_err++;
      $display("FAIL reset_out: valid=%b data=%h expected 0/00", cmd_valid, cmd_data);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      n_cmp++;
      if (rd !== exp_rd[i]) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, rd, exp_rd[i]);
      end
    end
  endtask

  task automatic test_control();
    logic [31:0] exp_c;
    bus_write(2'd2, 32'h38);
`ifdef OGPU_CMD_IRQ_EN
    exp_c = 32'h1;
`else
    exp_c = 32'h0;
`endif
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== exp_c) begin
      n_err++;
      $display("FAIL ctrl_read: got %h expected %h", rd, exp_c);
    end
    bus_write(2'd2, 32'h08);
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL ctrl_disable: got %h expected 0", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] cmds [5];
    cmds[0] = 32'h11; cmds[1] = 32'h22; cmds[2] = 32'h33; cmds[3] = 32'h44; cmds[4] = 32'h55;
    cmd_ready = 1'b0;
    foreach (cmds[i]) bus_write(2'd0, cmds[i]);
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'hE04) begin
      n_err++;
      $display("FAIL ovf_status: got %h expected 00000e04", rd);
    end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'h44) begin
      n_err++;
      $display("FAIL ovf_last_cmd: got %h expected 00000044", rd);
    end
    bus_write(2'd2, 32'h2);
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'hA04) begin
      n_err++;
      $display("FAIL ovf_clear: got %h expected 00000a04", rd);
    end
    bus_write(2'd0, 32'h66);
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'hE04) begin
      n_err++;
      $display("FAIL ovf_reset: got %h expected 00000e04", rd);
    end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'h44) begin
      n_err++;
      $display("FAIL ovf_drop_last: got %h expected 00000044", rd);
    end
    bus_write(2'd2, 32'h2);
  endtask

  task automatic test_drain();
    m_pops    = 0;
    cmd_ready = 1'b1;
    repeat (4) cyc();
    n_cmp++;
    if (m_pops != 4 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_count: pops=%0d valid=%b expected 4 pops valid=0", m_pops, cmd_valid);
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h900) begin
      n_err++;
      $display("FAIL drain_status: got %h expected 00000900", rd);
    end
  endtask

  task automatic test_done();
    pulse_done(4);
    bus_read(2'd3, rd);
    n_cmp++;
    if (rd !== 32'd4) begin
      n_err++;
      $display("FAIL done_count: got %h expected 00000004", rd);
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h100) begin
      n_err++;
      $display("FAIL done_idle: got %h expected 00000100", rd);
    end
    cmd_done = 1'b1;
    bus_write(2'd2, 32'h4);
    cmd_done = 1'b0;
    bus_read(2'd3, rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("FAIL done_clear_wins: got %h expected 00000000", rd);
    end
    pulse_done(1);
    bus_read(2'd3, rd);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_err++;
      $display("FAIL done_saturate_count: got %h expected 00000001", rd);
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h100) begin
      n_err++;
      $display("FAIL done_saturate_busy: got %h expected 00000100", rd);
    end
    bus_write(2'd2, 32'h4);
  endtask

  task automatic test_back_to_back();
    int unsigned n_out;
    cmd_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) bus_write(2'd0, 32'hA0 + i);
    m_pops    = 0;
    cmd_ready = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      bus_write(2'd0, 32'hB0 + i);
      address = 2'd1;
      #1;
      rd = readdata;
      n_cmp++;
      if (rd !== 32'hA04) begin
        n_err++;
        $display("FAIL b2b_level%0d: got %h expected 00000a04", i, rd);
      end
    end
    bus_write(2'd2, 32'h1);
    cmd_ready = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_valid: got %b expected 0", cmd_valid);
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h900) begin
      n_err++;
      $display("FAIL flush_status: got %h expected 00000900", rd);
    end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'hB5) begin
      n_err++;
      $display("FAIL flush_last_cmd: got %h expected 000000b5", rd);
    end
    n_out = m_pops;
    pulse_done(n_out - 1);
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h900) begin
      n_err++;
      $display("FAIL flush_outstanding: got %h expected 00000900 (pops=%0d)", rd, n_out);
    end
    pulse_done(1);
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h100) begin
      n_err++;
      $display("FAIL flush_retired: got %h expected 00000100", rd);
    end
    bus_read(2'd3, rd);
    n_cmp++;
    if (rd !== n_out) begin
      n_err++;
      $display("FAIL flush_done_count: got %h expected %h", rd, n_out);
    end
    bus_write(2'd2, 32'h4);
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    bus_write(2'd0, 32'hC1);
    bus_write(2'd0, 32'hC2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_valid: got %b expected 0", cmd_valid);
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'h100) begin
      n_err++;
      $display("FAIL rst_mid_status: got %h expected 00000100", rd);
    end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_last: got %h expected 00000000", rd);
    end
  endtask

`ifdef OGPU_CMD_IRQ_EN
  task automatic test_irq();
    bus_write(2'd2, 32'h18);
    cmd_ready = 1'b1;
    bus_write(2'd0, 32'h77);
    cyc();
    cmd_ready = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_idle: got %b expected 0", irq);
    end
    pulse_done(1);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== 32'h3) begin
      n_err++;
      $display("FAIL irq_ctrl_read: got %h expected 00000003", rd);
    end
    bus_write(2'd2, 32'h20);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cmd_ready  = 1'b0;
    cmd_done   = 1'b0;
    #1;
    test_reset();
    test_control();
    test_overflow();
    test_drain();
    test_done();
    test_back_to_back();
    test_reset_mid();
`ifdef OGPU_CMD_IRQ_EN
    test_irq();
`endif
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
